key_debounce_bank: RTL and testbench
====================================

KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter CH_NUM, default 4, number of independent key channels (1..32).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, where 1 means a pressed key reads 0 at i_key.
REQ-004 SHALL have parameter DEBOUNCE_MS, default 5, stability window in ms; DEB_CYC = CLK_FRE/1000*DEBOUNCE_MS.
REQ-005 SHALL have parameter LONG_MS, default 1000, long-press threshold in ms; LONG_CYC = CLK_FRE/1000*LONG_MS.
REQ-006 SHALL have port i_clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit, reset, synchronous, active-high.
REQ-008 SHALL have port i_key, input, CH_NUM bits, raw asynchronous key pins.
REQ-009 SHALL have port o_level, output, CH_NUM bits, debounced state, 1 = pressed.
REQ-010 SHALL have port o_press, output, CH_NUM bits, one-cycle pulse on a debounced press.
REQ-011 SHALL have port o_release, output, CH_NUM bits, one-cycle pulse on a debounced release.
REQ-012 SHALL have port o_long, output, CH_NUM bits, one-cycle pulse when a press has lasted LONG_CYC cycles.

Function
REQ-013 Each i_key bit SHALL pass through a 2-flop synchronizer, then be normalised to active-high (inverted when ACTIVE_LOW=1).
REQ-014 Each channel SHALL run an FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 IDLE: sample=1 -> PRESS_WAIT with deb counter cleared to 0; otherwise stay.
REQ-016 PRESS_WAIT: sample=0 -> IDLE and counter cleared (bounce); sample=1 -> counter increments; on the edge where counter = DEB_CYC-1 and sample=1 -> PRESSED.
REQ-017 RELEASE_WAIT SHALL mirror PRESS_WAIT with polarity swapped, returning to PRESSED on bounce and entering IDLE after DEB_CYC consecutive 0 samples.
REQ-018 PRESSED: sample=0 -> RELEASE_WAIT; o_level SHALL stay 1 throughout PRESSED and RELEASE_WAIT.
REQ-019 o_press SHALL be asserted for exactly the one cycle following the PRESS_WAIT->PRESSED transition, coincident with o_level rising.
REQ-020 o_release SHALL be asserted for exactly the one cycle coincident with o_level falling.
REQ-021 Total latency from a clean i_key edge to the o_level change SHALL be DEB_CYC+2 clock cycles.
REQ-022 A hold counter SHALL clear on entry to PRESSED, increment each cycle in PRESSED or RELEASE_WAIT, and saturate at LONG_CYC.
REQ-023 o_long SHALL pulse once when the hold counter first reaches LONG_CYC; it SHALL NOT repeat until a new press.
REQ-024 A release bounce (RELEASE_WAIT -> PRESSED) SHALL NOT clear the hold counter.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-026 Counter widths SHALL be $clog2(DEB_CYC+1) and $clog2(LONG_CYC+1); counters SHALL never wrap.

Reset
REQ-027 On i_rst=1 all FSMs SHALL go to IDLE, all counters to 0, synchronizer flops to the released level, and o_level/o_press/o_release/o_long to 0.
REQ-028 Reset asserted mid-debounce or mid-press SHALL abort with no pulse emitted; a key held through reset deassertion SHALL yield o_press DEB_CYC+2 cycles after deassertion.

Structure
REQ-029 A shared package key_pkg SHALL hold the channel-state enum and an ms_to_cycles constant function.
REQ-030 The channel logic SHALL be one sub-module key_debounce_ch, instantiated CH_NUM times by a generate loop.

Verification (CLK_FRE=1000, DEBOUNCE_MS=5 -> DEB_CYC=5, LONG_MS=20 -> LONG_CYC=20, CH_NUM=4, ACTIVE_LOW=1)
REQ-031 Clean press: i_key[0] goes 1->0 and is held -> o_press[0] and o_level[0] rise exactly 7 cycles later, with o_press one cycle wide.
REQ-032 Bounce: i_key[1] low for 4 cycles, high for 1, then low held -> no pulse during the glitch; o_press[1] 7 cycles after the final fall.
REQ-033 Long press: hold ch2 for 40 cycles -> one o_long[2] pulse 20 cycles after o_press[2]; release -> o_release[2] 7 cycles after the rise.
REQ-034 Simultaneous events: ch0 and ch3 pressed on the same cycle -> o_press = 4'b1001 for one cycle.
REQ-035 Reset mid-operation: i_rst pulsed 3 cycles into PRESS_WAIT with the key still held -> no pulse; o_press 7 cycles after i_rst falls.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce bank.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } key_state_e;

    typedef struct packed {
        logic level;
        logic press;
        logic rls;
        logic lng;
    } key_evt_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_fre, input int unsigned ms);
        return clk_fre / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, and long-press hold timer.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 5,
    parameter int unsigned LONG_CYC   = 20,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_key,
    output key_evt_t o_evt
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0);

    logic [1:0]    sync_q;
    logic          sample;
    key_state_e    state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          press_q, press_d;
    logic          rls_q, rls_d;
    logic          lng_q, lng_d;
    logic          held;

    // XOR with the idle level normalises the pin to 1 = pressed
    assign sample = sync_q[1] ^ IDLE_LVL;
    assign held   = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= {2{IDLE_LVL}};
        else       sync_q <= {sync_q[0], i_key};
    end

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        press_d = 1'b0;
        rls_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample) begin
                    state_d = ST_PRESS_WAIT;
                    deb_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sample) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sample) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sample) begin
                    state_d = ST_PRESSED;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    rls_d   = 1'b1;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                deb_d   = '0;
            end
        endcase
    end

    // Hold timer survives release bounces; only a fresh press restarts it
    always_comb begin
        hold_d = hold_q;
        lng_d  = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (held && hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
            lng_d  = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            press_q <= 1'b0;
            rls_q   <= 1'b0;
            lng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            press_q <= press_d;
            rls_q   <= rls_d;
            lng_q   <= lng_d;
        end
    end

    assign o_evt.level = held;
    assign o_evt.press = press_q;
    assign o_evt.rls   = rls_q;
    assign o_evt.lng   = lng_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of CH_NUM independent debounced keys with press/release/long-press pulses.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int unsigned CLK_FRE     = 50_000_000,
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned DEBOUNCE_MS = 5,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CH_NUM-1:0] i_key,
    output logic [CH_NUM-1:0] o_level,
    output logic [CH_NUM-1:0] o_press,
    output logic [CH_NUM-1:0] o_release,
    output logic [CH_NUM-1:0] o_long
);

    localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_FRE, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FRE, LONG_MS);

    key_evt_t ch_evt [CH_NUM];

    for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYC    (DEB_CYC),
            .LONG_CYC   (LONG_CYC),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_key (i_key[g]),
            .o_evt (ch_evt[g])
        );
        assign o_level[g]   = ch_evt[g].level;
        assign o_press[g]   = ch_evt[g].press;
        assign o_release[g] = ch_evt[g].rls;
        assign o_long[g]    = ch_evt[g].lng;
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank at DEB_CYC=5, LONG_CYC=20, 4 active-low keys.
module tb_key_debounce_bank;

    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_key;
    logic [3:0] o_level, o_press, o_release, o_long;

    int n_vec = 0;
    int n_bad = 0;
    int press_cnt [4] = '{0, 0, 0, 0};
    int rls_cnt   [4] = '{0, 0, 0, 0};
    int long_cnt  [4] = '{0, 0, 0, 0};

    key_debounce_bank #(
        .CLK_FRE     (1000),
        .CH_NUM      (4),
        .ACTIVE_LOW  (1),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_key     (i_key),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Pulse tally, one sample per cycle away from the active edge
    always @(negedge i_clk) begin
        for (int c = 0; c < 4; c++) begin
            press_cnt[c] += int'(o_press[c]);
            rls_cnt[c]   += int'(o_release[c]);
            long_cnt[c]  += int'(o_long[c]);
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Key already driven; first edge captures it, o_level moves 7 edges after that
    task automatic wait_edge(input string tag, input logic [3:0] lvl_pre, input logic [3:0] lvl_post,
                             input logic [3:0] pr, input logic [3:0] rl);
        step();
        repeat (6) step();
        chk({tag, "_lvl_pre"}, o_level, lvl_pre);
        chk({tag, "_pulse_pre"}, o_press | o_release, 4'h0);
        step();
        chk({tag, "_lvl_post"}, o_level, lvl_post);
        chk({tag, "_press"}, o_press, pr);
        chk({tag, "_release"}, o_release, rl);
        step();
        chk({tag, "_pulse_end"}, o_press | o_release, 4'h0);
        chk({tag, "_lvl_hold"}, o_level, lvl_post);
    endtask

    initial begin
        i_rst = 1'b1;
        i_key = 4'hF;
        repeat (3) step();
        chk("rst_level", o_level, 4'h0);
        chk("rst_pulses", o_press | o_release | o_long, 4'h0);
        i_rst = 1'b0;

        // clean press/release on ch0
        i_key = 4'b1110;
        wait_edge("t1_press", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        i_key = 4'hF;
        wait_edge("t1_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        // bounce on ch1: 4 low, 1 high, then held low
        i_key = 4'b1101;
        repeat (4) begin
            step();
            chk("t2_glitch_lo", o_level | o_press, 4'h0);
        end
        i_key = 4'hF;
        step();
        chk("t2_glitch_hi", o_level | o_press, 4'h0);
        i_key = 4'b1101;
        wait_edge("t2_press", 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        i_key = 4'hF;
        wait_edge("t2_rel", 4'b0010, 4'b0000, 4'b0000, 4'b0010);

        // long press on ch2, held 40 cycles
        i_key = 4'b1011;
        wait_edge("t3_press", 4'b0000, 4'b0100, 4'b0100, 4'b0000);
        repeat (18) step();
        chk("t3_long_early", o_long, 4'h0);
        step();
        chk("t3_long", o_long, 4'b0100);
        step();
        chk("t3_long_end", o_long, 4'h0);
        repeat (11) step();
        i_key = 4'hF;
        wait_edge("t3_rel", 4'b0100, 4'b0000, 4'b0000, 4'b0100);

        // simultaneous ch0 + ch3
        i_key = 4'b0110;
        wait_edge("t4_press", 4'b0000, 4'b1001, 4'b1001, 4'b0000);
        i_key = 4'hF;
        wait_edge("t4_rel", 4'b1001, 4'b0000, 4'b0000, 4'b1001);

        // reset 3 cycles into PRESS_WAIT with ch0 still held
        i_key = 4'b1110;
        step();
        repeat (4) step();
        i_rst = 1'b1;
        step();
        chk("t5_rst_a", o_level | o_press, 4'h0);
        step();
        chk("t5_rst_b", o_level | o_press, 4'h0);
        i_rst = 1'b0;
        wait_edge("t5_press", 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        i_key = 4'hF;
        wait_edge("t5_rel", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        step();
        chk("cnt_press0", 4'(press_cnt[0]), 4'd3);
        chk("cnt_press1", 4'(press_cnt[1]), 4'd1);
        chk("cnt_press2", 4'(press_cnt[2]), 4'd1);
        chk("cnt_press3", 4'(press_cnt[3]), 4'd1);
        chk("cnt_rel0", 4'(rls_cnt[0]), 4'd3);
        chk("cnt_long0", 4'(long_cnt[0]), 4'd0);
        chk("cnt_long2", 4'(long_cnt[2]), 4'd1);
        chk("cnt_long3", 4'(long_cnt[3]), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
